thor2024_head: RTL and testbench



---
 rtl/thor2024_head.sv | 105 ++++++++++
 tb/tb_thor2024_head.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/thor2024_head.sv
// rtl/thor2024_head.sv - commit-side head pointer manager for the Thor2024 issue queue
// Retires up to two completed entries per cycle in order, skipping stomped slots.
module thor2024_head #(
  parameter int QENTRIES        = 8,
  parameter int SUPPORT_COMMIT2 = 1,
  parameter int ICNT_W          = 40,
  localparam int NW             = $clog2(QENTRIES)
) (
  input  logic                rst,
  input  logic                clk,
  input  logic [QENTRIES-1:0] iq_v,
  input  logic [QENTRIES-1:0] iq_done,
  input  logic [QENTRIES-1:0] iq_exc,
  input  logic [NW-1:0]       tail0,
  input  logic                commit_stall,
  output logic [NW-1:0]       head0,
  output logic [NW-1:0]       head1,
  output logic                commit0_v,
  output logic                commit1_v,
  output logic [NW-1:0]       commit0_ndx,
  output logic [NW-1:0]       commit1_ndx,
  output logic [QENTRIES-1:0] iq_clr,
  output logic                exc_v,
  output logic [NW-1:0]       exc_ndx,
  output logic [ICNT_W-1:0]   icnt
);

  logic [NW-1:0]       r_head0;
  logic                r_commit0_v;
  logic                r_commit1_v;
  logic [NW-1:0]       r_commit0_ndx;
  logic [NW-1:0]       r_commit1_ndx;
  logic [QENTRIES-1:0] r_iq_clr;
  logic                r_exc_v;
  logic [NW-1:0]       r_exc_ndx;
  logic [ICNT_W-1:0]   r_icnt;

  logic [NW-1:0]       w_head1;
  logic                w_ret0, w_skip0, w_exc0, w_take0;
  logic                w_ret1, w_skip1, w_exc1, w_take1;
  logic                w_commit1;
  logic [NW-1:0]       w_adv;
  logic [QENTRIES-1:0] w_clr;
  logic [ICNT_W-1:0]   w_ret_cnt;

  assign w_head1 = r_head0 + NW'(1);

  assign w_ret0  = iq_v[r_head0] & iq_done[r_head0] & ~commit_stall;
  assign w_skip0 = ~iq_v[r_head0] & (r_head0 != tail0);
  assign w_exc0  = w_ret0 & iq_exc[r_head0];
  assign w_take0 = w_ret0 | w_skip0;

  // An excepting entry at head1 must first become head0 before it can retire.
  assign w_ret1  = iq_v[w_head1] & iq_done[w_head1] & ~commit_stall;
  assign w_skip1 = ~iq_v[w_head1] & (w_head1 != tail0);
  assign w_exc1  = iq_v[w_head1] & iq_exc[w_head1];
  assign w_take1 = w_take0 & ~w_exc0 & (w_ret1 | w_skip1) & (w_head1 != tail0)
                 & (SUPPORT_COMMIT2 != 0) & ~w_exc1;

  assign w_commit1 = w_take1 & w_ret1;
  assign w_adv     = NW'(w_take0) + NW'(w_take1);
  assign w_ret_cnt = ICNT_W'(w_ret0) + ICNT_W'(w_commit1);

  always_comb begin
    w_clr = '0;
    if (w_take0) w_clr[r_head0] = 1'b1;
    if (w_take1) w_clr[w_head1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head0       <= '0;
      r_commit0_v   <= 1'b0;
      r_commit1_v   <= 1'b0;
      r_commit0_ndx <= '0;
      r_commit1_ndx <= '0;
      r_iq_clr      <= '0;
      r_exc_v       <= 1'b0;
      r_exc_ndx     <= '0;
      r_icnt        <= '0;
    end else begin
      r_head0     <= r_head0 + w_adv;
      r_commit0_v <= w_ret0;
      r_commit1_v <= w_commit1;
      r_iq_clr    <= w_clr;
      r_exc_v     <= w_exc0;
      r_icnt      <= r_icnt + w_ret_cnt;
      if (w_ret0)    r_commit0_ndx <= r_head0;
      if (w_commit1) r_commit1_ndx <= w_head1;
      if (w_exc0)    r_exc_ndx     <= r_head0;
    end
  end

  assign head0       = r_head0;
  assign head1       = w_head1;
  assign commit0_v   = r_commit0_v;
  assign commit1_v   = r_commit1_v;
  assign commit0_ndx = r_commit0_ndx;
  assign commit1_ndx = r_commit1_ndx;
  assign iq_clr      = r_iq_clr;
  assign exc_v       = r_exc_v;
  assign exc_ndx     = r_exc_ndx;
  assign icnt        = r_icnt;

endmodule

// File: tb/tb_thor2024_head.sv
// tb/tb_thor2024_head.sv - scoreboard bench for thor2024_head (dual- and single-commit builds)
module tb_thor2024_head;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] v, dn, ex;
  logic [2:0] t;
  logic       st;

  logic [2:0]  a_h0, a_h1, a_c0n, a_c1n, a_exn, b_h0, b_h1, b_c0n, b_c1n, b_exn;
  logic        a_c0v, a_c1v, a_exv, b_c0v, b_c1v, b_exv;
  logic [7:0]  a_clr, b_clr;
  logic [39:0] a_ic, b_ic;

  thor2024_head #(.QENTRIES(8), .SUPPORT_COMMIT2(1), .ICNT_W(40)) dut_a (
    .rst(rst), .clk(clk), .iq_v(v), .iq_done(dn), .iq_exc(ex), .tail0(t),
    .commit_stall(st), .head0(a_h0), .head1(a_h1), .commit0_v(a_c0v),
    .commit1_v(a_c1v), .commit0_ndx(a_c0n), .commit1_ndx(a_c1n),
    .iq_clr(a_clr), .exc_v(a_exv), .exc_ndx(a_exn), .icnt(a_ic));

  thor2024_head #(.QENTRIES(8), .SUPPORT_COMMIT2(0), .ICNT_W(40)) dut_b (
    .rst(rst), .clk(clk), .iq_v(v), .iq_done(dn), .iq_exc(ex), .tail0(t),
    .commit_stall(st), .head0(b_h0), .head1(b_h1), .commit0_v(b_c0v),
    .commit1_v(b_c1v), .commit0_ndx(b_c0n), .commit1_ndx(b_c1n),
    .iq_clr(b_clr), .exc_v(b_exv), .exc_ndx(b_exn), .icnt(b_ic));

  always #5 clk = ~clk;

  typedef struct {
    bit c0v, c1v, exv;
    int c0n, c1n, exn, n, rets;
    logic [7:0] clr;
  } dec_t;

  typedef struct {
    int head;
    logic [39:0] icnt;
    dec_t d;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t mon_a, mon_b, last_b;
  int mh[2];
  logic [39:0] mi[2];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: walk the queue from the head and consume slots by the retire rules.
  function automatic dec_t decide(int h, bit dual);
    dec_t r;
    int slot;
    bit ret[2], skp[2];
    r = '{default: 0};
    for (int k = 0; k < 2; k++) begin
      slot   = (h + k) % Q;
      ret[k] = v[slot] && dn[slot] && !st;
      skp[k] = !v[slot] && (slot != int'(t));
    end
    if (!(ret[0] || skp[0]))            r.n = 0;
    else if (ret[0] && ex[h])           r.n = 1;
    else if ((ret[1] || skp[1]) && ((h + 1) % Q) != int'(t) && dual &&
             !(v[(h + 1) % Q] && ex[(h + 1) % Q])) r.n = 2;
    else                                r.n = 1;
    for (int k = 0; k < r.n; k++) begin
      slot = (h + k) % Q;
      r.clr[slot] = 1'b1;
      if (ret[k]) begin
        r.rets++;
        if (k == 0) begin r.c0v = 1; r.c0n = slot; end
        else        begin r.c1v = 1; r.c1n = slot; end
      end
    end
    if (r.n >= 1 && ret[0] && ex[h]) begin r.exv = 1; r.exn = h; end
    return r;
  endfunction

  function automatic exp_t predict(int k);
    exp_t e;
    e.d   = decide(mh[k], k == 0);
    mh[k] = (mh[k] + e.d.n) % Q;
    mi[k] = mi[k] + 40'(e.d.rets);
    e.head = mh[k];
    e.icnt = mi[k];
    return e;
  endfunction

  task automatic step();
    exp_t ea, eb;
    ea = predict(0);
    eb = predict(1);
    last_b = eb;
    @(posedge clk);
    qa.push_back(ea);
    qb.push_back(eb);
    #1;
  endtask

  task automatic cmp(string tg, exp_t e, logic [2:0] h0, logic [2:0] h1, logic c0v,
                     logic c1v, logic [2:0] c0n, logic [2:0] c1n, logic [7:0] clr,
                     logic exv, logic [2:0] exn, logic [39:0] ic);
    chk({tg, " head0"}, 64'(h0), 64'(e.head));
    chk({tg, " head1"}, 64'(h1), 64'((e.head + 1) % Q));
    chk({tg, " commit0_v"}, 64'(c0v), 64'(e.d.c0v));
    chk({tg, " commit1_v"}, 64'(c1v), 64'(e.d.c1v));
    chk({tg, " iq_clr"}, 64'(clr), 64'(e.d.clr));
    chk({tg, " exc_v"}, 64'(exv), 64'(e.d.exv));
    chk({tg, " icnt"}, 64'(ic), 64'(e.icnt));
    if (e.d.c0v) chk({tg, " commit0_ndx"}, 64'(c0n), 64'(e.d.c0n));
    if (e.d.c1v) chk({tg, " commit1_ndx"}, 64'(c1n), 64'(e.d.c1n));
    if (e.d.exv) chk({tg, " exc_ndx"}, 64'(exn), 64'(e.d.exn));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (qa.size() != 0) begin
        mon_a = qa.pop_front();
        cmp("A", mon_a, a_h0, a_h1, a_c0v, a_c1v, a_c0n, a_c1n, a_clr, a_exv, a_exn, a_ic);
      end
      if (qb.size() != 0) begin
        mon_b = qb.pop_front();
        cmp("B", mon_b, b_h0, b_h1, b_c0v, b_c1v, b_c0n, b_c1n, b_clr, b_exv, b_exn, b_ic);
      end
    end
  end

  task automatic chk_reset();
    chk("rst head0", 64'({a_h0, b_h0}), 64'h0);
    chk("rst head1", 64'({a_h1, b_h1}), 64'o11);
    chk("rst commit_v", 64'({a_c0v, a_c1v, b_c0v, b_c1v}), 64'h0);
    chk("rst commit_ndx", 64'({a_c0n, a_c1n, b_c0n, b_c1n}), 64'h0);
    chk("rst iq_clr", 64'({a_clr, b_clr}), 64'h0);
    chk("rst exc", 64'({a_exv, a_exn, b_exv, b_exn}), 64'h0);
    chk("rst icnt", 64'(a_ic | b_ic), 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset();
    qa.delete();
    qb.delete();
    mh[0] = 0; mh[1] = 0;
    mi[0] = '0; mi[1] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_in(logic [7:0] iv, logic [7:0] id, logic [7:0] ie, logic [2:0] it, logic is);
    v = iv; dn = id; ex = ie; t = it; st = is;
  endtask

  initial begin
    rst = 1'b1;
    set_in(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
    #3;
    do_reset();

    set_in(8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    repeat (5) step();
    chk("empty head0", 64'(a_h0), 64'd0);

    set_in(8'h03, 8'h03, 8'h01, 3'd2, 1'b0);
    step();
    chk("exc exc_v", 64'({a_exv, a_exn}), 64'h8);
    chk("exc commit", 64'({a_c0v, a_c1v, a_h0}), 64'h11);
    chk("exc icnt", 64'(a_ic), 64'd1);

    do_reset();
    set_in(8'h03, 8'h03, 8'h00, 3'd2, 1'b0);
    step();
    chk("dual head0", 64'(a_h0), 64'd2);
    chk("dual iq_clr", 64'(a_clr), 64'h03);
    chk("dual ndx", 64'({a_c1v, a_c1n}), 64'h9);
    set_in(8'h04, 8'h04, 8'h00, 3'd3, 1'b0);
    step();
    set_in(8'h20, 8'h00, 8'h00, 3'd6, 1'b0);
    step();
    chk("skip head0", 64'(a_h0), 64'd5);
    chk("skip iq_clr", 64'(a_clr), 64'h18);
    chk("skip commit_v", 64'({a_c0v, a_c1v}), 64'h0);
    chk("skip icnt", 64'(a_ic), 64'd3);
    set_in(8'h60, 8'h60, 8'h00, 3'd7, 1'b0);
    step();
    set_in(8'h81, 8'h81, 8'h00, 3'd1, 1'b1);
    repeat (2) step();
    chk("stall head0", 64'(a_h0), 64'd7);
    st = 1'b0;
    step();
    chk("wrap head", 64'({a_h0, a_h1}), 64'o12);
    chk("wrap ndx", 64'({a_c1v, a_c1n}), 64'h8);
    chk("wrap icnt", 64'(a_ic), 64'd7);

    do_reset();
    set_in(8'h0F, 8'h0F, 8'h00, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single head0", 64'(b_h0), 64'(i + 1));
      v  = v & ~last_b.d.clr;
      dn = dn & ~last_b.d.clr;
    end

    for (int i = 0; i < 400; i++) begin
      v  = 8'($urandom);
      dn = 8'($urandom);
      ex = 8'($urandom) & 8'($urandom) & 8'($urandom) & v;
      t  = 3'($urandom);
      st = ($urandom_range(0, 3) == 0);
      step();
    end

    #2;
    do_reset();
    set_in(8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    #1;
    chk("scoreboard drained", 64'(qa.size() + qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
